csr_trap_unit: RTL

- Parametrised machine-mode CSR file and trap controller; successor to the single-hart M-mode CSR block.
- Adds N local interrupt lines, a vectored mtvec mode and the mstatus.MIE global gate.
- Adds CSR set/clear ops, 64-bit mcycle/minstret counters, and a post-trap flush FSM that blocks re-trapping while the pipeline drains.
- Sits beside ID/EX; drives pipeline flushes and the fetch redirect.

---
 rtl/csr_trap_unit.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/write, interrupt and exception
// arbitration, fetch redirect, pipeline flushes and a post-trap flush FSM.

package csr_trap_unit_pkg;
    typedef struct packed {
        logic        vld;
        logic [31:0] cause;
        logic [31:0] tval;
    } exception_t;
endpackage

module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int unsigned NUM_LOCAL_IRQ = 4,
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              if_pc_i,
    input  logic [31:0]              id_pc_i,
    input  logic [31:0]              ex_pc_i,
    input  exception_t               if_exception_i,
    input  exception_t               id_exception_i,
    input  exception_t               ex_exception_i,
    input  logic                     id_mret_i,
    input  logic [31:0]              fetch_pc_i,
    input  logic                     soft_irq_i,
    input  logic                     timer_irq_i,
    input  logic                     ex_irq_i,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq_i,
    input  logic                     instr_retire_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [1:0]               csr_op_i,
    input  logic [31:0]              csr_wdata_i,
    output logic [31:0]              csr_rdata_o,
    output logic                     csr_illegal_o,
    output logic                     if_flush_o,
    output logic                     id_flush_o,
    output logic                     ex_flush_o,
    output logic                     interrupt_flush_o,
    output logic                     redirect_vld_o,
    output logic [31:0]              fetch_addr_o,
    output logic                     flush_busy_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // RV32 with I, M, B and K extension bits
    localparam logic [31:0] MISA_VALUE = 32'h4000_1502;
    localparam logic [31:0] LOCAL_MASK = ((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;
    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {StRun, StFlush} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        implemented, read_only, csr_we;
    logic [31:0] csr_wval;
    logic [31:0] pending;
    logic [4:0]  irq_code;
    logic        any_exc, exc_take, irq_take, mret_take, trap;
    logic [31:0] exc_cause, exc_tval, exc_pc;

    // Combinational CSR read and legality decode
    always_comb begin
        csr_rdata_o = 32'h0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr_addr_i)
            ADDR_MSTATUS:   csr_rdata_o = {19'h0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0,
                                           mstatus_mie_q, 3'b0};
            ADDR_MISA:      begin csr_rdata_o = MISA_VALUE; read_only = 1'b1; end
            ADDR_MIE:       csr_rdata_o = mie_q;
            ADDR_MIP:       begin csr_rdata_o = mip_q; read_only = 1'b1; end
            ADDR_MTVEC:     csr_rdata_o = mtvec_q;
            ADDR_MSCRATCH:  csr_rdata_o = mscratch_q;
            ADDR_MEPC:      csr_rdata_o = mepc_q;
            ADDR_MCAUSE:    csr_rdata_o = mcause_q;
            ADDR_MTVAL:     csr_rdata_o = mtval_q;
            ADDR_MCYCLE:    csr_rdata_o = mcycle_q[31:0];
            ADDR_MCYCLEH:   csr_rdata_o = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_rdata_o = minstret_q[31:0];
            ADDR_MINSTRETH: csr_rdata_o = minstret_q[63:32];
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: read_only = 1'b1;
            ADDR_MHARTID:   begin csr_rdata_o = HART_ID; read_only = 1'b1; end
            default:        implemented = 1'b0;
        endcase
        csr_illegal_o = !implemented || (read_only && csr_op_i == 2'b01);
        csr_we        = (csr_op_i != 2'b00) && implemented && !read_only;
        case (csr_op_i)
            2'b01:   csr_wval = csr_wdata_i;
            2'b10:   csr_wval = csr_rdata_o | csr_wdata_i;
            2'b11:   csr_wval = csr_rdata_o & ~csr_wdata_i;
            default: csr_wval = csr_rdata_o;
        endcase
    end

    // Interrupt priority: ext > soft > timer > local (lowest index first)
    always_comb begin
        pending  = mip_q & mie_q;
        irq_code = 5'd0;
        for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--) begin
            if (pending[16+k]) irq_code = 5'(16 + k);
        end
        if (pending[7])  irq_code = 5'd7;
        if (pending[3])  irq_code = 5'd3;
        if (pending[11]) irq_code = 5'd11;
    end

    // Trap arbitration and redirect outputs
    always_comb begin
        if_flush_o = 1'b0;
        id_flush_o = 1'b0;
        ex_flush_o = 1'b0;
        exc_cause  = if_exception_i.cause;
        exc_tval   = if_exception_i.tval;
        exc_pc     = if_pc_i;
        any_exc    = ex_exception_i.vld || id_exception_i.vld || if_exception_i.vld;
        exc_take   = (state_q == StRun) && any_exc;
        if (ex_exception_i.vld) begin
            exc_cause  = ex_exception_i.cause;
            exc_tval   = ex_exception_i.tval;
            exc_pc     = ex_pc_i;
            ex_flush_o = exc_take;
        end else if (id_exception_i.vld) begin
            exc_cause  = id_exception_i.cause;
            exc_tval   = id_exception_i.tval;
            exc_pc     = id_pc_i;
            id_flush_o = exc_take;
        end else begin
            if_flush_o = exc_take;
        end
        irq_take = (state_q == StRun) && mstatus_mie_q && (|pending) && !any_exc && !id_mret_i;
        mret_take = (state_q == StRun) && id_mret_i && !any_exc;
        trap              = exc_take || irq_take;
        interrupt_flush_o = irq_take;
        redirect_vld_o    = trap || mret_take;
        flush_busy_o      = (state_q == StFlush);
        fetch_addr_o      = 32'h0;
        if (trap) begin
            fetch_addr_o = {mtvec_q[31:2], 2'b00};
            if (irq_take && mtvec_q[1:0] == 2'b01) begin
                fetch_addr_o = fetch_addr_o + {25'h0, irq_code, 2'b00};
            end
        end else if (mret_take) begin
            fetch_addr_o = mepc_q;
        end
    end

    // CSR next state: software write first, trap/mret update overrides it
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'h0, instr_retire_i};
        mip_d          = 32'h0;
        mip_d[3]       = soft_irq_i;
        mip_d[7]       = timer_irq_i;
        mip_d[11]      = ex_irq_i;
        mip_d[16 +: NUM_LOCAL_IRQ] = local_irq_i;
        if (csr_we) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_wval[3];
                    mstatus_mpie_d = csr_wval[7];
                end
                ADDR_MIE:       mie_d      = csr_wval & MIE_MASK;
                ADDR_MTVEC:     mtvec_d    = {csr_wval[31:2], 1'b0, csr_wval[0]};
                ADDR_MSCRATCH:  mscratch_d = csr_wval;
                ADDR_MEPC:      mepc_d     = {csr_wval[31:2], 2'b00};
                ADDR_MCAUSE:    mcause_d   = csr_wval;
                ADDR_MTVAL:     mtval_d    = csr_wval;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wval};
                ADDR_MCYCLEH:   mcycle_d   = {csr_wval, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wval};
                ADDR_MINSTRETH: minstret_d = {csr_wval, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (trap) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            if (exc_take) begin
                mcause_d = exc_cause;
                mepc_d   = {exc_pc[31:2], 2'b00};
                mtval_d  = exc_tval;
            end else begin
                mcause_d = {1'b1, 26'h0, irq_code};
                mepc_d   = {fetch_pc_i[31:2], 2'b00};
                mtval_d  = 32'h0;
            end
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // Flush FSM next state: hold off further traps while the pipeline drains
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRun: begin
                if (redirect_vld_o) begin
                    state_d = StFlush;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            StFlush: begin
                if (cnt_q == 3'd0) state_d = StRun;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = StRun;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StRun;
            cnt_q          <= 3'd0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mip_q          <= 32'h0;
            mtvec_q        <= MTVEC_RESET & 32'hFFFF_FFFD;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule
